dma_cmd_queue: RTL and testbench
================================

# dma_cmd_queue

Memory-mapped front end for the DMA controller. It sits between the core's MMIO store/load path and `dma_ctrl`: the core stages src/dst/width and posts commands into a small FIFO without stalling. The block issues one command at a time to `dma_ctrl` using the `cmd`/`stall` protocol and reports status, completions and errors. The core stalls only on an explicit fence.

## Interface
- `DEPTH`, 4: command FIFO entries; power of 2, ≥2.
- `CW`, $clog2(DEPTH)+1: width of the count field.
---
- `clk`  in  1  clock
- `reset`  in  1  reset, asynchronous, active-high
- `cpuAddress`  in  5  byte offset within the block; bits [1:0] ignored
- `cpuWriteData`  in  32  MMIO write data
- `cpuWriteEnable`  in  1  MMIO write strobe, one cycle per store
- `cpuReadData`  out  32  combinational read of the register at `cpuAddress`
- `cpuStall`  out  1  fence in progress; holds the core
- `dmaCmd`  out  2  to `dma_ctrl.cmd`: 00 none, 01 D2S, 10 S2D
- `dmaSrcAddress`, `dmaDstAddress`  out  32  to `dma_ctrl`; registered
- `dmaWidth`  out  10  to `dma_ctrl.width`; registered
- `dmaStall`  in  1  from `dma_ctrl.stall`; high while the engine is not DORMANT
- `dmaDone`  out  1  one-cycle pulse when a command completes

## Operation
- Register map (word offsets):
  - 0x00 SRC (rw)
  - 0x04 DST (rw)
  - 0x08 WIDTH (rw, [9:0]; reads 0 above bit 9)
  - 0x0C CMD/STATUS
  - 0x10 FENCE (wo)
  - 0x14 CLEAR (wo)
  - Unmapped addresses read 0; writes to them are ignored.
- CMD write, kind = `cpuWriteData[1:0]`:
  - 00: ignored.
  - 01 or 10 with WIDTH≠0: pushes {kind, SRC, DST, WIDTH}.
  - 11, or WIDTH==0: not pushed; sets sticky `err`.
  - Push while full: dropped; sets sticky `ovf`.
- STATUS read: bit31 `ovf`, bit30 `err`, bit16 `busy` (FSM≠IDLE), [8+CW-1:8] FIFO count, [7:0] `doneCount` (wraps at 255).
- FENCE write sets `fencePending`.
  - `cpuStall = fencePending & !(fifoEmpty & state==IDLE)`.
  - `fencePending` clears on the first cycle that condition is false.
- CLEAR write: bit0 clears `ovf` and `err`; bit1 clears `doneCount`. A CLEAR in the same cycle as a setting event: the set wins.
- FSM:
  - IDLE: FIFO non-empty → ISSUE. On this edge, pop the head into the `dma*` output registers.
  - ISSUE: `dmaCmd`=kind → WAIT_START.
  - WAIT_START: `dmaCmd`=00. If `dmaStall` → WAIT_DONE; else → IDLE and set `err` (engine rejected the command, e.g. S2D not implemented).
  - WAIT_DONE: when `!dmaStall` → IDLE, pulse `dmaDone`, `doneCount`+1.
- `dmaCmd` is nonzero only in ISSUE, for exactly one cycle.
- `dma*` address/width outputs hold their value until the next pop.
- Staging registers are never modified by a push, so repeated CMD writes reuse the same SRC/DST/WIDTH.

## Timing
- Reset values:
  - All outputs 0.
  - FSM IDLE, FIFO empty.
  - Staging registers, `ovf`, `err`, `doneCount` and `fencePending` all 0.
- Reset mid-transfer returns to IDLE and empties the FIFO. `dma_ctrl` shares the same reset.
- Writes take effect at the clock edge of the write cycle; STATUS reflects them the next cycle.
- Latency from a CMD write at cycle N with an idle engine and empty FIFO:
  - N+1: count=1, IDLE.
  - N+2: ISSUE, `dmaCmd`=01, count=0.
  - N+3: WAIT_START with `dmaStall`=1.
- `dmaDone` is asserted in the cycle after the first cycle in which `dmaStall` is seen low during WAIT_DONE.
- Push and pop on the same edge:
  - Count is unchanged.
  - When full, the push is accepted because the pop frees the slot in the same edge.
- FIFO pointers are log2(DEPTH) bits and wrap; full/empty come from the count.
- FENCE written while already idle and empty: `cpuStall` never asserts.

## Structure
- `dma_pkg`:
  - `dma_cmd_t` enum (DMA_NONE=00, DMA_D2S=01, DMA_S2D=10), shared with `dma_ctrl`.
  - Register offset constants.
  - STATUS bit positions.
  - FSM state enum.
- One sub-module, `cmd_fifo`:
  - Synchronous FIFO, parameters DEPTH and width (76 = 2+32+32+10).
  - Ports: push, pop, din, dout (head, combinational), count, full, empty.

## Test plan
- SRC=0x1000, DST=0x40, WIDTH=4, CMD=01:
  - `dmaCmd`=01 for exactly one cycle, 2 cycles after the write.
  - Outputs carry 0x1000/0x40/4.
  - One `dmaDone` pulse after the stub deasserts stall.
  - STATUS[7:0]=1.
- Five CMD=01 writes back-to-back with the engine stub held busy:
  - count=4.
  - `ovf`=1 after the 5th write.
  - Exactly 4 issues in FIFO order.
- CMD=11, and CMD=01 with WIDTH=0:
  - Nothing is issued.
  - `err`=1.
  - CLEAR bit0 → STATUS bit30=0.
- Stub never raises stall on an S2D command: the FSM returns to IDLE from WAIT_START and `err`=1.
- Three queued commands, then FENCE:
  - `cpuStall` is high until the third `dmaDone` cycle's engine-idle point.
  - Then low.
  - `fencePending` cleared.
- Reset asserted during WAIT_DONE with 2 entries queued: STATUS reads 0 and `dmaCmd` stays 00 after release.

Source files
------------

// File: rtl/dma_pkg.sv
// Shared types and constants for the DMA command queue front end.
// The command encoding is also used by dma_ctrl, so keep it in sync.
package dma_pkg;

  typedef enum logic [1:0] {
    DMA_NONE = 2'b00,
    DMA_D2S  = 2'b01,
    DMA_S2D  = 2'b10
  } dma_cmd_t;

  localparam logic [4:0] REG_SRC   = 5'h00;
  localparam logic [4:0] REG_DST   = 5'h04;
  localparam logic [4:0] REG_WIDTH = 5'h08;
  localparam logic [4:0] REG_CMD   = 5'h0C;
  localparam logic [4:0] REG_FENCE = 5'h10;
  localparam logic [4:0] REG_CLEAR = 5'h14;

  localparam int STAT_OVF       = 31;
  localparam int STAT_ERR       = 30;
  localparam int STAT_BUSY      = 16;
  localparam int STAT_COUNT_LSB = 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT_START,
    ST_WAIT_DONE
  } state_t;

  typedef struct packed {
    dma_cmd_t    kind;
    logic [31:0] src;
    logic [31:0] dst;
    logic [9:0]  width;
  } cmd_entry_t;

  localparam int ENTRY_W = $bits(cmd_entry_t);

endpackage

// File: rtl/cmd_fifo.sv
// Small synchronous FIFO holding posted DMA commands.
// Head is visible combinationally; a pop frees a slot for a push on the same edge.
module cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 76,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wrPtr_q, wrPtr_d;
  logic [AW-1:0]    rdPtr_q, rdPtr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             doPush, doPop;

  assign full   = (count_q == CW'(DEPTH));
  assign empty  = (count_q == '0);
  assign doPop  = pop && !empty;
  assign doPush = push && (!full || doPop);
  assign dout   = mem_q[rdPtr_q];
  assign count  = count_q;

  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    count_d = count_q;
    if (doPush) wrPtr_d = wrPtr_q + AW'(1);
    if (doPop)  rdPtr_d = rdPtr_q + AW'(1);
    case ({doPush, doPop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
      count_q <= count_d;
    end
  end

  // Storage needs no reset: empty/count gate every use of it.
  always_ff @(posedge clk) begin
    if (doPush) mem_q[wrPtr_q] <= din;
  end

endmodule

// File: rtl/dma_cmd_queue.sv
// MMIO front end for dma_ctrl: stages SRC/DST/WIDTH, posts commands into a FIFO
// and issues them one at a time over the cmd/stall handshake.
module dma_cmd_queue
  import dma_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  cpuAddress,
  input  logic [31:0] cpuWriteData,
  input  logic        cpuWriteEnable,
  output logic [31:0] cpuReadData,
  output logic        cpuStall,
  output logic [1:0]  dmaCmd,
  output logic [31:0] dmaSrcAddress,
  output logic [31:0] dmaDstAddress,
  output logic [9:0]  dmaWidth,
  input  logic        dmaStall,
  output logic        dmaDone
);

  state_t      state_q, state_d;
  logic [31:0] stageSrc_q, stageSrc_d;
  logic [31:0] stageDst_q, stageDst_d;
  logic [9:0]  stageWidth_q, stageWidth_d;
  logic        ovf_q, ovf_d;
  logic        err_q, err_d;
  logic [7:0]  doneCount_q, doneCount_d;
  logic        fencePending_q, fencePending_d;
  dma_cmd_t    dmaKind_q;
  logic [31:0] dmaSrc_q, dmaDst_q;
  logic [9:0]  dmaWidth_q;
  logic        dmaDone_q;

  logic [4:0]  regAddr;
  logic [1:0]  unusedAddrBits;
  logic        wrSrc, wrDst, wrWidth, wrCmd, wrFence, wrClear;
  logic [1:0]  cmdKind;
  logic        cmdValid, cmdBad, ovfSet, rejectErr, doneEvent, idleEmpty;
  logic        fifoPop, fifoFull, fifoEmpty;
  logic [CW-1:0] fifoCount;
  cmd_entry_t  pushEntry, headEntry;

  assign regAddr        = {cpuAddress[4:2], 2'b00};
  assign unusedAddrBits = cpuAddress[1:0];
  assign wrSrc   = cpuWriteEnable && (regAddr == REG_SRC);
  assign wrDst   = cpuWriteEnable && (regAddr == REG_DST);
  assign wrWidth = cpuWriteEnable && (regAddr == REG_WIDTH);
  assign wrCmd   = cpuWriteEnable && (regAddr == REG_CMD);
  assign wrFence = cpuWriteEnable && (regAddr == REG_FENCE);
  assign wrClear = cpuWriteEnable && (regAddr == REG_CLEAR);

  assign cmdKind  = cpuWriteData[1:0];
  assign cmdValid = wrCmd && (cmdKind == 2'b01 || cmdKind == 2'b10) && (stageWidth_q != '0);
  assign cmdBad   = wrCmd && ((cmdKind == 2'b11) || (cmdKind != 2'b00 && stageWidth_q == '0));

  assign fifoPop   = (state_q == ST_IDLE) && !fifoEmpty;
  assign ovfSet    = cmdValid && fifoFull && !fifoPop;
  assign rejectErr = (state_q == ST_WAIT_START) && !dmaStall;
  assign doneEvent = (state_q == ST_WAIT_DONE) && !dmaStall;
  assign idleEmpty = fifoEmpty && (state_q == ST_IDLE);

  assign pushEntry.kind  = dma_cmd_t'(cmdKind);
  assign pushEntry.src   = stageSrc_q;
  assign pushEntry.dst   = stageDst_q;
  assign pushEntry.width = stageWidth_q;

  cmd_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W),
    .CW    (CW)
  ) uFifo (
    .clk   (clk),
    .reset (reset),
    .push  (cmdValid),
    .pop   (fifoPop),
    .din   (pushEntry),
    .dout  (headEntry),
    .count (fifoCount),
    .full  (fifoFull),
    .empty (fifoEmpty)
  );

  // Issue sequencer: one command in flight, engine acceptance seen via stall.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:       if (!fifoEmpty) state_d = ST_ISSUE;
      ST_ISSUE:      state_d = ST_WAIT_START;
      ST_WAIT_START: state_d = dmaStall ? ST_WAIT_DONE : ST_IDLE;
      ST_WAIT_DONE:  if (!dmaStall) state_d = ST_IDLE;
      default:       state_d = ST_IDLE;
    endcase
  end

  // Setting events are applied after CLEAR so they win on a collision.
  always_comb begin
    stageSrc_d     = wrSrc   ? cpuWriteData       : stageSrc_q;
    stageDst_d     = wrDst   ? cpuWriteData       : stageDst_q;
    stageWidth_d   = wrWidth ? cpuWriteData[9:0]  : stageWidth_q;
    ovf_d          = ovf_q;
    err_d          = err_q;
    doneCount_d    = doneCount_q;
    fencePending_d = fencePending_q && !idleEmpty;
    if (wrClear && cpuWriteData[0]) begin
      ovf_d = 1'b0;
      err_d = 1'b0;
    end
    if (wrClear && cpuWriteData[1]) doneCount_d = '0;
    if (ovfSet)                     ovf_d = 1'b1;
    if (cmdBad || rejectErr)        err_d = 1'b1;
    if (doneEvent)                  doneCount_d = doneCount_q + 8'd1;
    if (wrFence)                    fencePending_d = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      stageSrc_q     <= '0;
      stageDst_q     <= '0;
      stageWidth_q   <= '0;
      ovf_q          <= 1'b0;
      err_q          <= 1'b0;
      doneCount_q    <= '0;
      fencePending_q <= 1'b0;
      dmaKind_q      <= DMA_NONE;
      dmaSrc_q       <= '0;
      dmaDst_q       <= '0;
      dmaWidth_q     <= '0;
      dmaDone_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      stageSrc_q     <= stageSrc_d;
      stageDst_q     <= stageDst_d;
      stageWidth_q   <= stageWidth_d;
      ovf_q          <= ovf_d;
      err_q          <= err_d;
      doneCount_q    <= doneCount_d;
      fencePending_q <= fencePending_d;
      dmaDone_q      <= doneEvent;
      if (fifoPop) begin
        dmaKind_q  <= headEntry.kind;
        dmaSrc_q   <= headEntry.src;
        dmaDst_q   <= headEntry.dst;
        dmaWidth_q <= headEntry.width;
      end
    end
  end

  assign dmaCmd        = (state_q == ST_ISSUE) ? dmaKind_q : DMA_NONE;
  assign dmaSrcAddress = dmaSrc_q;
  assign dmaDstAddress = dmaDst_q;
  assign dmaWidth      = dmaWidth_q;
  assign dmaDone       = dmaDone_q;
  assign cpuStall      = fencePending_q && !idleEmpty;

  always_comb begin
    cpuReadData = '0;
    case (regAddr)
      REG_SRC:   cpuReadData = stageSrc_q;
      REG_DST:   cpuReadData = stageDst_q;
      REG_WIDTH: cpuReadData[9:0] = stageWidth_q;
      REG_CMD: begin
        cpuReadData[STAT_OVF]                   = ovf_q;
        cpuReadData[STAT_ERR]                   = err_q;
        cpuReadData[STAT_BUSY]                  = (state_q != ST_IDLE);
        cpuReadData[STAT_COUNT_LSB +: CW]       = fifoCount;
        cpuReadData[7:0]                        = doneCount_q;
      end
      default:   cpuReadData = '0;
    endcase
  end

endmodule

// File: tb/tb_dma_cmd_queue.sv
// Directed bench for dma_cmd_queue with a simple dma_ctrl stub that only
// accepts D2S commands and holds stall for a programmable number of cycles.
module tb_dma_cmd_queue;

  localparam logic [4:0] A_SRC = 5'h00, A_DST = 5'h04, A_WIDTH = 5'h08;
  localparam logic [4:0] A_CMD = 5'h0C, A_FENCE = 5'h10, A_CLEAR = 5'h14;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  cpuAddress;
  logic [31:0] cpuWriteData;
  logic        cpuWriteEnable;
  logic [31:0] cpuReadData;
  logic        cpuStall;
  logic [1:0]  dmaCmd;
  logic [31:0] dmaSrcAddress, dmaDstAddress;
  logic [9:0]  dmaWidth;
  logic        dmaStall;
  logic        dmaDone;

  int checks = 0;
  int errors = 0;

  logic        stubHold;
  int          stubLen;
  int          stubCnt;
  logic [1:0]  issueKind [$];
  logic [31:0] issueSrc  [$];

  dma_cmd_queue dut (
    .clk            (clk),
    .reset          (reset),
    .cpuAddress     (cpuAddress),
    .cpuWriteData   (cpuWriteData),
    .cpuWriteEnable (cpuWriteEnable),
    .cpuReadData    (cpuReadData),
    .cpuStall       (cpuStall),
    .dmaCmd         (dmaCmd),
    .dmaSrcAddress  (dmaSrcAddress),
    .dmaDstAddress  (dmaDstAddress),
    .dmaWidth       (dmaWidth),
    .dmaStall       (dmaStall),
    .dmaDone        (dmaDone)
  );

  always #5 clk = ~clk;

  // Engine stub: D2S starts a transfer, S2D is silently rejected.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      dmaStall <= 1'b0;
      stubCnt  <= 0;
    end else if (dmaCmd == 2'b01) begin
      dmaStall <= 1'b1;
      stubCnt  <= stubLen;
    end else if (dmaStall && !stubHold) begin
      if (stubCnt <= 1) dmaStall <= 1'b0;
      else              stubCnt  <= stubCnt - 1;
    end
  end

  always @(negedge clk) begin
    if (dmaCmd != 2'b00) begin
      issueKind.push_back(dmaCmd);
      issueSrc.push_back(dmaSrcAddress);
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Called at a negedge; the write is captured on the following posedge.
  task automatic applyStimulus(input logic [4:0] addr, input logic [31:0] data);
    cpuAddress     = addr;
    cpuWriteData   = data;
    cpuWriteEnable = 1'b1;
    @(negedge clk);
    cpuWriteEnable = 1'b0;
  endtask

  task automatic readReg(input logic [4:0] addr, output logic [31:0] data);
    cpuAddress = addr;
    #1;
    data = cpuReadData;
  endtask

  task automatic waitForDone(input int maxCycles, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < maxCycles; i++) begin
      @(negedge clk);
      if (dmaDone) begin
        seen = 1'b1;
        break;
      end
    end
  endtask

  initial begin
    logic [31:0] rd;
    bit          seen;
    int          n;
    int          cnt;

    reset = 1'b1; cpuAddress = '0; cpuWriteData = '0; cpuWriteEnable = 1'b0;
    stubHold = 1'b0; stubLen = 3;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    checkOutput("rst_dmaCmd", 32'(dmaCmd), 32'h0);
    checkOutput("rst_cpuStall", 32'(cpuStall), 32'h0);
    checkOutput("rst_dmaSrc", dmaSrcAddress, 32'h0);
    readReg(A_CMD, rd);
    checkOutput("rst_status", rd, 32'h0);

    // Single D2S transfer
    applyStimulus(A_SRC, 32'h1000);
    applyStimulus(A_DST, 32'h40);
    applyStimulus(A_WIDTH, 32'd4);
    readReg(A_SRC, rd);   checkOutput("src_rb", rd, 32'h1000);
    readReg(A_WIDTH, rd); checkOutput("width_rb", rd, 32'd4);
    issueKind.delete(); issueSrc.delete();
    applyStimulus(A_CMD, 32'h1);
    readReg(A_CMD, rd);   checkOutput("t1_count1", rd, 32'h0000_0100);
    checkOutput("t1_cmd_n1", 32'(dmaCmd), 32'h0);
    @(negedge clk);
    checkOutput("t1_cmd_n2", 32'(dmaCmd), 32'h1);
    checkOutput("t1_src", dmaSrcAddress, 32'h1000);
    checkOutput("t1_dst", dmaDstAddress, 32'h40);
    checkOutput("t1_width", 32'(dmaWidth), 32'd4);
    readReg(A_CMD, rd);   checkOutput("t1_busy", rd, 32'h0001_0000);
    @(negedge clk);
    checkOutput("t1_cmd_n3", 32'(dmaCmd), 32'h0);
    waitForDone(30, seen);
    checkOutput("t1_done_seen", 32'(seen), 32'h1);
    readReg(A_CMD, rd);   checkOutput("t1_status_done", rd, 32'h0000_0001);
    @(negedge clk);
    checkOutput("t1_done_pulse", 32'(dmaDone), 32'h0);
    checkOutput("t1_src_hold", dmaSrcAddress, 32'h1000);
    checkOutput("t1_issues", 32'(issueKind.size()), 32'd1);

    // Overflow with engine held busy; FIFO order preserved
    stubHold = 1'b1;
    issueKind.delete(); issueSrc.delete();
    applyStimulus(A_SRC, 32'h2000);
    applyStimulus(A_CMD, 32'h1);
    repeat (4) @(negedge clk);
    for (int i = 1; i <= 5; i++) begin
      applyStimulus(A_SRC, 32'h2000 + 32'(i));
      applyStimulus(A_CMD, 32'h1);
    end
    readReg(A_CMD, rd);   checkOutput("t2_full_ovf", rd, 32'h8001_0401);
    stubHold = 1'b0;
    n = 0;
    for (int i = 0; i < 300 && n < 5; i++) begin
      @(negedge clk);
      if (dmaDone) n++;
    end
    checkOutput("t2_done_count", 32'(n), 32'd5);
    @(negedge clk);
    checkOutput("t2_issues", 32'(issueSrc.size()), 32'd5);
    for (int k = 0; k < 5; k++) begin
      if (k < issueSrc.size())
        checkOutput($sformatf("t2_order%0d", k), issueSrc[k], 32'h2000 + 32'(k));
    end
    readReg(A_CMD, rd);   checkOutput("t2_status_end", rd, 32'h8000_0006);
    applyStimulus(A_CLEAR, 32'h3);
    readReg(A_CMD, rd);   checkOutput("t2_cleared", rd, 32'h0);

    // Bad commands, register boundaries
    applyStimulus(A_WIDTH, 32'hFFFF_FFFF);
    readReg(A_WIDTH, rd); checkOutput("width_mask", rd, 32'h3FF);
    readReg(5'h02, rd);   checkOutput("addr_lowbits", rd, 32'h2005);
    applyStimulus(5'h18, 32'hDEAD_BEEF);
    readReg(5'h18, rd);   checkOutput("unmapped", rd, 32'h0);
    readReg(A_FENCE, rd); checkOutput("fence_read0", rd, 32'h0);
    applyStimulus(A_WIDTH, 32'd4);
    issueKind.delete(); issueSrc.delete();
    applyStimulus(A_CMD, 32'h0);
    repeat (3) @(negedge clk);
    readReg(A_CMD, rd);   checkOutput("t3_kind0", rd, 32'h0);
    applyStimulus(A_CMD, 32'h3);
    readReg(A_CMD, rd);   checkOutput("t3_kind3_err", rd, 32'h4000_0000);
    applyStimulus(A_CLEAR, 32'h1);
    readReg(A_CMD, rd);   checkOutput("t3_clr1", rd, 32'h0);
    applyStimulus(A_WIDTH, 32'd0);
    applyStimulus(A_CMD, 32'h1);
    readReg(A_CMD, rd);   checkOutput("t3_w0_err", rd, 32'h4000_0000);
    repeat (4) @(negedge clk);
    checkOutput("t3_no_issue", 32'(issueKind.size()), 32'd0);
    applyStimulus(A_CLEAR, 32'h1);
    readReg(A_CMD, rd);   checkOutput("t3_clr2", rd, 32'h0);

    // S2D rejected by the engine
    applyStimulus(A_WIDTH, 32'd8);
    issueKind.delete(); issueSrc.delete();
    applyStimulus(A_CMD, 32'h2);
    repeat (4) @(negedge clk);
    readReg(A_CMD, rd);   checkOutput("t4_reject_err", rd, 32'h4000_0000);
    checkOutput("t4_issues", 32'(issueKind.size()), 32'd1);
    if (issueKind.size() > 0) checkOutput("t4_kind", 32'(issueKind[0]), 32'h2);
    checkOutput("t4_width", 32'(dmaWidth), 32'd8);
    applyStimulus(A_CLEAR, 32'h1);

    // Fence behind three queued commands
    applyStimulus(A_CMD, 32'h1);
    applyStimulus(A_CMD, 32'h1);
    applyStimulus(A_CMD, 32'h1);
    applyStimulus(A_FENCE, 32'h0);
    checkOutput("t5_stall_on", 32'(cpuStall), 32'h1);
    n = 0; seen = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (!cpuStall) begin
        seen = 1'b1;
        break;
      end
      if (dmaDone) n++;
    end
    checkOutput("t5_stall_released", 32'(seen), 32'h1);
    checkOutput("t5_dones_stalled", 32'(n), 32'd2);
    checkOutput("t5_done_at_release", 32'(dmaDone), 32'h1);
    @(negedge clk);
    checkOutput("t5_stall_stays_low", 32'(cpuStall), 32'h0);
    readReg(A_CMD, rd);   checkOutput("t5_status", rd, 32'h0000_0003);
    applyStimulus(A_FENCE, 32'h0);
    checkOutput("t5_idle_fence_a", 32'(cpuStall), 32'h0);
    @(negedge clk);
    checkOutput("t5_idle_fence_b", 32'(cpuStall), 32'h0);

    // Reset in WAIT_DONE with two queued
    stubHold = 1'b1;
    applyStimulus(A_CMD, 32'h1);
    applyStimulus(A_CMD, 32'h1);
    applyStimulus(A_CMD, 32'h1);
    repeat (4) @(negedge clk);
    readReg(A_CMD, rd);   checkOutput("t6_pre_reset", rd, 32'h0001_0203);
    reset = 1'b1;
    readReg(A_CMD, rd);   checkOutput("t6_async_reset", rd, 32'h0);
    repeat (2) @(negedge clk);
    stubHold = 1'b0;
    reset = 1'b0;
    cnt = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (dmaCmd != 2'b00) cnt++;
    end
    checkOutput("t6_no_issue", 32'(cnt), 32'd0);
    readReg(A_CMD, rd);   checkOutput("t6_status", rd, 32'h0);
    readReg(A_SRC, rd);   checkOutput("t6_src_stage", rd, 32'h0);
    checkOutput("t6_dmaSrc", dmaSrcAddress, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
